// File: rtl/wb_fml_bridge_pkg.sv
// Shared FML bus widths, default burst length and the bridge state encoding.
package wb_fml_bridge_pkg;
    localparam int FML_ADR_W = 26;
    localparam int FML_DAT_W = 32;
    localparam int FML_BE_W  = 4;
    localparam int FML_BURST = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WDATA,
        S_WCMD,
        S_RCMD,
        S_RDATA,
        S_ACK
    } state_e;

    // Byte-offset bits covered by one burst-aligned line.
    function automatic int line_off_w(input int burst);
        return $clog2(burst) + 2;
    endfunction
endpackage

// File: rtl/fml_line_buf.sv
// One-line read buffer: burst words, tag, valid flag, byte-merge write port, async read.
module fml_line_buf
    import wb_fml_bridge_pkg::*;
#(
    parameter int burst = FML_BURST,
    parameter int TAG_W = 32 - line_off_w(FML_BURST)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [$clog2(burst)-1:0] wr_idx,
    input  logic [FML_DAT_W-1:0]     wr_dat,
    input  logic [FML_BE_W-1:0]      wr_be,
    input  logic                     set_valid,
    input  logic [TAG_W-1:0]         set_tag,
    input  logic [$clog2(burst)-1:0] rd_idx,
    output logic [FML_DAT_W-1:0]     rd_dat,
    output logic [TAG_W-1:0]         tag,
    output logic                     valid
);
    logic [burst-1:0][FML_DAT_W-1:0] line_q, line_d;
    logic [TAG_W-1:0]                tag_q, tag_d;
    logic                            valid_q, valid_d;

    always_comb begin
        line_d  = line_q;
        tag_d   = set_valid ? set_tag : tag_q;
        valid_d = valid_q | set_valid;
        if (wr_en) begin
            for (int b = 0; b < FML_BE_W; b++) begin
                if (wr_be[b]) line_d[wr_idx][8*b +: 8] = wr_dat[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            line_q  <= '0;
            tag_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            line_q  <= line_d;
            tag_q   <= tag_d;
            valid_q <= valid_d;
        end
    end

    assign rd_dat = line_q[rd_idx];
    assign tag    = tag_q;
    assign valid  = valid_q;
endmodule

// File: rtl/wb_fml_bridge.sv
// Wishbone classic slave to FML burst master with a one-line read buffer.
module wb_fml_bridge
    import wb_fml_bridge_pkg::*;
#(
    parameter int burst    = FML_BURST,
    parameter bit use_lbuf = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          wb_adr_i,
    input  logic [31:0]          wb_dat_i,
    output logic [31:0]          wb_dat_o,
    input  logic [3:0]           wb_sel_i,
    input  logic                 wb_we_i,
    input  logic                 wb_stb_i,
    input  logic                 wb_cyc_i,
    output logic                 wb_ack_o,
    output logic [FML_ADR_W-1:0] fml_adr,
    output logic                 fml_rd,
    output logic                 fml_wr,
    input  logic                 fml_done,
    output logic [FML_DAT_W-1:0] fml_wdat,
    output logic [FML_BE_W-1:0]  fml_wbe,
    output logic                 fml_wnext,
    input  logic                 fml_rempty,
    output logic                 fml_rnext,
    input  logic [FML_DAT_W-1:0] fml_rdat
);
    localparam int BW = $clog2(burst);
    localparam int OW = line_off_w(burst);
    localparam int TW = 32 - OW;

    state_e state_q, state_d;
    logic [31:0]          adr_q, adr_d, dat_q, dat_d, wb_dat_q, wb_dat_d;
    logic [3:0]           sel_q, sel_d;
    logic [BW-1:0]        beat_q, beat_d;
    logic                 wb_ack_q, wb_ack_d, fml_rd_q, fml_rd_d, fml_wr_q, fml_wr_d;
    logic                 fml_wnext_q, fml_wnext_d, fml_rnext_q, fml_rnext_d;
    logic [FML_ADR_W-1:0] fml_adr_q, fml_adr_d;
    logic [FML_DAT_W-1:0] fml_wdat_q, fml_wdat_d;
    logic [FML_BE_W-1:0]  fml_wbe_q, fml_wbe_d;

    logic                 lb_we, lb_set, lb_valid;
    logic [BW-1:0]        lb_idx, lb_rd_idx;
    logic [FML_DAT_W-1:0] lb_dat, lb_rd_dat;
    logic [FML_BE_W-1:0]  lb_be;
    logic [TW-1:0]        lb_tag;

    logic          req, req_hit, cur_hit, rd_take, last_beat, wr_done, rd_done;
    logic [BW-1:0] req_word, cur_word;
    logic          unused_adr_bits;

    assign req       = wb_cyc_i & wb_stb_i & ~wb_ack_q;
    assign req_word  = wb_adr_i[OW-1:2];
    assign cur_word  = adr_q[OW-1:2];
    assign req_hit   = use_lbuf && lb_valid && (lb_tag == wb_adr_i[31:OW]);
    assign cur_hit   = use_lbuf && lb_valid && (lb_tag == adr_q[31:OW]);
    assign last_beat = (beat_q == BW'(burst - 1));
    assign wr_done   = (state_q == S_WCMD) && fml_done && fml_wr_q;
    assign rd_done   = (state_q == S_RCMD) && fml_done && fml_rd_q;
    // rnext is registered, so the beat under an in-flight pop must not be taken twice.
    assign rd_take   = (state_q == S_RDATA) && !fml_rempty && !fml_rnext_q;
    assign lb_rd_idx = (state_q == S_IDLE) ? req_word : cur_word;
    assign unused_adr_bits = ^{wb_adr_i[1:0], adr_q[1:0]};

    fml_line_buf #(.burst(burst), .TAG_W(TW)) u_lbuf (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (lb_we),
        .wr_idx   (lb_idx),
        .wr_dat   (lb_dat),
        .wr_be    (lb_be),
        .set_valid(lb_set),
        .set_tag  (adr_q[31:OW]),
        .rd_idx   (lb_rd_idx),
        .rd_dat   (lb_rd_dat),
        .tag      (lb_tag),
        .valid    (lb_valid)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req) state_d = wb_we_i ? S_WDATA : (req_hit ? S_IDLE : S_RCMD);
            S_WDATA: if (last_beat) state_d = S_WCMD;
            S_WCMD:  if (wr_done) state_d = S_ACK;
            S_RCMD:  if (rd_done) state_d = S_RDATA;
            S_RDATA: if (rd_take && last_beat) state_d = S_ACK;
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        adr_d       = adr_q;
        dat_d       = dat_q;
        sel_d       = sel_q;
        beat_d      = beat_q;
        wb_dat_d    = wb_dat_q;
        wb_ack_d    = 1'b0;
        fml_adr_d   = fml_adr_q;
        fml_rd_d    = fml_rd_q;
        fml_wr_d    = fml_wr_q;
        fml_wnext_d = 1'b0;
        fml_rnext_d = 1'b0;
        fml_wdat_d  = fml_wdat_q;
        fml_wbe_d   = fml_wbe_q;
        lb_we       = 1'b0;
        lb_set      = 1'b0;
        lb_idx      = beat_q;
        lb_dat      = fml_rdat;
        lb_be       = '1;
        case (state_q)
            S_IDLE: if (req) begin
                if (wb_we_i || !req_hit) begin
                    adr_d     = wb_adr_i;
                    dat_d     = wb_dat_i;
                    sel_d     = wb_sel_i;
                    beat_d    = '0;
                    fml_adr_d = {wb_adr_i[FML_ADR_W-1:OW], {OW{1'b0}}};
                    fml_rd_d  = !wb_we_i;
                end else begin
                    wb_dat_d = lb_rd_dat;
                    wb_ack_d = 1'b1;
                end
            end
            S_WDATA: begin
                fml_wnext_d = 1'b1;
                fml_wdat_d  = dat_q;
                fml_wbe_d   = (beat_q == cur_word) ? sel_q : '0;
                beat_d      = beat_q + BW'(1);
            end
            S_WCMD: begin
                fml_wr_d = !wr_done;
                // Keep the buffered line coherent with the write just committed.
                if (wr_done && cur_hit) begin
                    lb_we  = 1'b1;
                    lb_idx = cur_word;
                    lb_dat = dat_q;
                    lb_be  = sel_q;
                end
            end
            S_RCMD: if (rd_done) begin
                fml_rd_d = 1'b0;
                beat_d   = '0;
            end
            S_RDATA: if (rd_take) begin
                fml_rnext_d = 1'b1;
                lb_we       = 1'b1;
                beat_d      = beat_q + BW'(1);
                if (last_beat) begin
                    lb_set   = use_lbuf;
                    wb_dat_d = (cur_word == beat_q) ? fml_rdat : lb_rd_dat;
                end
            end
            S_ACK:   wb_ack_d = wb_cyc_i;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            adr_q       <= '0;
            dat_q       <= '0;
            sel_q       <= '0;
            beat_q      <= '0;
            wb_dat_q    <= '0;
            wb_ack_q    <= 1'b0;
            fml_adr_q   <= '0;
            fml_rd_q    <= 1'b0;
            fml_wr_q    <= 1'b0;
            fml_wnext_q <= 1'b0;
            fml_rnext_q <= 1'b0;
            fml_wdat_q  <= '0;
            fml_wbe_q   <= '0;
        end else begin
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            sel_q       <= sel_d;
            beat_q      <= beat_d;
            wb_dat_q    <= wb_dat_d;
            wb_ack_q    <= wb_ack_d;
            fml_adr_q   <= fml_adr_d;
            fml_rd_q    <= fml_rd_d;
            fml_wr_q    <= fml_wr_d;
            fml_wnext_q <= fml_wnext_d;
            fml_rnext_q <= fml_rnext_d;
            fml_wdat_q  <= fml_wdat_d;
            fml_wbe_q   <= fml_wbe_d;
        end
    end

    assign wb_dat_o  = wb_dat_q;
    assign wb_ack_o  = wb_ack_q;
    assign fml_adr   = fml_adr_q;
    assign fml_rd    = fml_rd_q;
    assign fml_wr    = fml_wr_q;
    assign fml_wnext = fml_wnext_q;
    assign fml_rnext = fml_rnext_q;
    assign fml_wdat  = fml_wdat_q;
    assign fml_wbe   = fml_wbe_q;
endmodule

// File: tb/tb_wb_fml_bridge.sv
// Bench for wb_fml_bridge: behavioural ddr_ctrl/FIFO model plus a read-data scoreboard.
module tb_wb_fml_bridge;
    localparam int BURST = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] wb_adr_i = '0, wb_dat_i = '0, wb_dat_o;
    logic [3:0]  wb_sel_i = '0;
    logic        wb_we_i = 1'b0, wb_stb_i = 1'b0, wb_cyc_i = 1'b0, wb_ack_o;
    logic [25:0] fml_adr;
    logic        fml_rd, fml_wr, fml_done, fml_wnext, fml_rempty, fml_rnext;
    logic [31:0] fml_wdat, fml_rdat;
    logic [3:0]  fml_wbe;

    always #5 clk = ~clk;

    wb_fml_bridge #(.burst(BURST), .use_lbuf(1'b1)) dut (
        .clk(clk), .reset(rst),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_sel_i(wb_sel_i),
        .wb_we_i(wb_we_i), .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_ack_o(wb_ack_o),
        .fml_adr(fml_adr), .fml_rd(fml_rd), .fml_wr(fml_wr), .fml_done(fml_done),
        .fml_wdat(fml_wdat), .fml_wbe(fml_wbe), .fml_wnext(fml_wnext),
        .fml_rempty(fml_rempty), .fml_rnext(fml_rnext), .fml_rdat(fml_rdat)
    );

    int tests = 0, fails = 0;
    logic [31:0] ddr_mem [0:1023];
    logic [31:0] ref_mem [0:1023];
    logic [31:0] exp_q[$];
    logic [31:0] rfifo[$], pend[$];
    logic [35:0] wbeats[$];
    logic [3:0]  wbe_log[$];
    int rnext_cnt = 0, rnext_err = 0, rd_cmds = 0, wr_cmds = 0, wnext_cnt = 0, ack_cnt = 0;
    int wbeats_at_wr = 0, cmd_lat = 0;
    logic [25:0] last_rd_adr = '0;
    bit toggle_mode = 0, tog = 0, pop_pend = 0, wr_prev = 0;

    function automatic int widx(input logic [31:0] a);
        return int'(a[11:2]);
    endfunction

    // ddr_ctrl + FWFT read FIFO model; a pop happens on the posedge where fml_rnext is high.
    initial begin
        fml_done = 1'b0; fml_rempty = 1'b1; fml_rdat = '0;
        for (int i = 0; i < 1024; i++) begin
            ddr_mem[i] = 32'hA000_0000 | i;
            ref_mem[i] = 32'hA000_0000 | i;
        end
        forever begin
            @(negedge clk);
            fml_done = 1'b0;
            if (rst) begin
                rfifo.delete(); pend.delete(); wbeats.delete();
                pop_pend = 0; cmd_lat = 0; wr_prev = 0;
            end else begin
                if (pop_pend && rfifo.size() > 0) void'(rfifo.pop_front());
                pop_pend = 0;
                if (fml_rnext) begin
                    rnext_cnt++;
                    if (rfifo.size() == 0) rnext_err++;
                    pop_pend = 1;
                end
                if (fml_wnext) begin
                    wbeats.push_back({fml_wbe, fml_wdat});
                    wnext_cnt++;
                end
                if (fml_wr && !wr_prev) wbeats_at_wr = wbeats.size();
                wr_prev = fml_wr;
                if (wb_ack_o) ack_cnt++;
                if (fml_rd || fml_wr) begin
                    if (cmd_lat == 2) begin
                        int base;
                        fml_done = 1'b1;
                        cmd_lat  = 0;
                        base     = int'(fml_adr[11:2]);
                        if (fml_rd) begin
                            rd_cmds++;
                            last_rd_adr = fml_adr;
                            for (int i = 0; i < BURST; i++) pend.push_back(ddr_mem[base + i]);
                        end else begin
                            wr_cmds++;
                            wbe_log.delete();
                            for (int i = 0; i < wbeats.size(); i++) begin
                                logic [35:0] b;
                                b = wbeats[i];
                                wbe_log.push_back(b[35:32]);
                                for (int j = 0; j < 4; j++)
                                    if (b[32+j]) ddr_mem[base + i][8*j +: 8] = b[8*j +: 8];
                            end
                            wbeats.delete();
                        end
                    end else cmd_lat++;
                end
                if (toggle_mode) begin
                    tog = !tog;
                    if (tog && pend.size() > 0) rfifo.push_back(pend.pop_front());
                end else begin
                    while (pend.size() > 0) rfifo.push_back(pend.pop_front());
                end
            end
            fml_rempty = (rfifo.size() == 0);
            fml_rdat   = fml_rempty ? 32'h0 : rfifo[0];
        end
    end

    task automatic wb_access(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                             input logic [3:0] sel, output logic ok, output logic [31:0] rdat,
                             output int lat);
        wb_adr_i = adr; wb_we_i = we; wb_dat_i = dat; wb_sel_i = sel;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        lat = 0;
        do begin @(negedge clk); lat++; end while (wb_ack_o !== 1'b1 && lat < 300);
        ok   = (wb_ack_o === 1'b1);
        rdat = wb_dat_o;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    endtask

    task automatic test_reset();
        tests++;
        if ({wb_ack_o, fml_rd, fml_wr, fml_wnext, fml_rnext} !== 5'b0) begin
            fails++; $display("FAIL reset_ctl: got %b want 00000", {wb_ack_o, fml_rd, fml_wr, fml_wnext, fml_rnext});
        end
        tests++;
        if (wb_dat_o !== 32'h0 || fml_adr !== 26'h0) begin
            fails++; $display("FAIL reset_data: dat_o=%h adr=%h want 0", wb_dat_o, fml_adr);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if ({wb_ack_o, fml_rd, fml_wr} !== 3'b0) begin
            fails++; $display("FAIL post_reset_idle: got %b want 000", {wb_ack_o, fml_rd, fml_wr});
        end
    endtask

    task automatic test_read_miss();
        logic ok; logic [31:0] d, e; int lat, r0, n0;
        r0 = rd_cmds; n0 = rnext_cnt;
        exp_q.push_back(ref_mem[widx(32'h100)]);
        wb_access(32'h100, 1'b0, 32'h0, 4'hF, ok, d, lat);
        repeat (2) @(negedge clk);
        e = exp_q.pop_front();
        tests++;
        if (!ok || d !== e) begin fails++; $display("FAIL miss_data: ok=%0b got %h want %h", ok, d, e); end
        tests++;
        if (rd_cmds - r0 != 1) begin fails++; $display("FAIL miss_rdcmd: got %0d want 1", rd_cmds - r0); end
        tests++;
        if (rnext_cnt - n0 != BURST) begin fails++; $display("FAIL miss_rnext: got %0d want %0d", rnext_cnt - n0, BURST); end
        tests++;
        if (last_rd_adr !== 26'h100) begin fails++; $display("FAIL miss_adr: got %h want 100", last_rd_adr); end
    endtask

    task automatic test_hit();
        logic ok; logic [31:0] d, e; int lat, r0;
        r0 = rd_cmds;
        exp_q.push_back(ref_mem[widx(32'h10C)]);
        wb_access(32'h10C, 1'b0, 32'h0, 4'hF, ok, d, lat);
        e = exp_q.pop_front();
        tests++;
        if (!ok || d !== e) begin fails++; $display("FAIL hit_data: ok=%0b got %h want %h", ok, d, e); end
        tests++;
        if (lat != 1) begin fails++; $display("FAIL hit_latency: got %0d want 1", lat); end
        tests++;
        if (rd_cmds != r0) begin fails++; $display("FAIL hit_no_fml: got %0d reads want 0", rd_cmds - r0); end
        exp_q.push_back(ref_mem[widx(32'h110)]);
        wb_access(32'h110, 1'b0, 32'h0, 4'hF, ok, d, lat);
        repeat (2) @(negedge clk);
        e = exp_q.pop_front();
        tests++;
        if (!ok || d !== e) begin fails++; $display("FAIL next_line_data: ok=%0b got %h want %h", ok, d, e); end
        tests++;
        if (rd_cmds - r0 != 1 || last_rd_adr !== 26'h110) begin
            fails++; $display("FAIL next_line_miss: reads=%0d adr=%h want 1 at 110", rd_cmds - r0, last_rd_adr);
        end
    endtask

    task automatic test_write();
        logic ok; logic [31:0] d, e; int lat, r0, w0, n0;
        logic [3:0] exp_be [4];
        exp_be = '{4'h0, 4'h3, 4'h0, 4'h0};
        exp_q.push_back(ref_mem[widx(32'h100)]);
        wb_access(32'h100, 1'b0, 32'h0, 4'hF, ok, d, lat);
        e = exp_q.pop_front();
        tests++;
        if (!ok || d !== e) begin fails++; $display("FAIL refill_data: ok=%0b got %h want %h", ok, d, e); end
        repeat (2) @(negedge clk);
        w0 = wr_cmds; n0 = wnext_cnt;
        ref_mem[widx(32'h104)][15:0] = 16'hBEEF;
        wb_access(32'h104, 1'b1, 32'hDEADBEEF, 4'b0011, ok, d, lat);
        repeat (2) @(negedge clk);
        tests++;
        if (!ok) begin fails++; $display("FAIL wr_ack: no ack within %0d cycles", lat); end
        tests++;
        if (wr_cmds - w0 != 1) begin fails++; $display("FAIL wr_cmd: got %0d want 1", wr_cmds - w0); end
        tests++;
        if (wnext_cnt - n0 != BURST) begin fails++; $display("FAIL wr_wnext: got %0d want %0d", wnext_cnt - n0, BURST); end
        tests++;
        if (wbeats_at_wr != BURST) begin fails++; $display("FAIL wr_data_first: beats before cmd %0d want %0d", wbeats_at_wr, BURST); end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (wbe_log.size() <= i || wbe_log[i] !== exp_be[i]) begin
                fails++; $display("FAIL wr_wbe[%0d]: got %h want %h", i, (wbe_log.size() > i) ? wbe_log[i] : 4'hx, exp_be[i]);
            end
        end
        tests++;
        if (ddr_mem[widx(32'h104)] !== ref_mem[widx(32'h104)]) begin
            fails++; $display("FAIL wr_mem: got %h want %h", ddr_mem[widx(32'h104)], ref_mem[widx(32'h104)]);
        end
        r0 = rd_cmds;
        exp_q.push_back(ref_mem[widx(32'h104)]);
        wb_access(32'h104, 1'b0, 32'h0, 4'hF, ok, d, lat);
        e = exp_q.pop_front();
        tests++;
        if (!ok || d !== e) begin fails++; $display("FAIL merge_data: ok=%0b got %h want %h", ok, d, e); end
        tests++;
        if (lat != 1 || rd_cmds != r0) begin fails++; $display("FAIL merge_hit: lat=%0d reads=%0d want 1/0", lat, rd_cmds - r0); end
    endtask

    task automatic test_rempty_toggle();
        logic ok; logic [31:0] d, e; int lat, n0, x0;
        toggle_mode = 1; n0 = rnext_cnt; x0 = rnext_err;
        exp_q.push_back(ref_mem[widx(32'h200)]);
        wb_access(32'h200, 1'b0, 32'h0, 4'hF, ok, d, lat);
        repeat (2) @(negedge clk);
        e = exp_q.pop_front();
        tests++;
        if (!ok || d !== e) begin fails++; $display("FAIL toggle_data: ok=%0b got %h want %h", ok, d, e); end
        tests++;
        if (rnext_cnt - n0 != BURST) begin fails++; $display("FAIL toggle_rnext: got %0d want %0d", rnext_cnt - n0, BURST); end
        tests++;
        if (rnext_err != x0) begin fails++; $display("FAIL toggle_rnext_empty: got %0d pops on empty want 0", rnext_err - x0); end
        exp_q.push_back(ref_mem[widx(32'h20C)]);
        wb_access(32'h20C, 1'b0, 32'h0, 4'hF, ok, d, lat);
        e = exp_q.pop_front();
        tests++;
        if (!ok || d !== e || lat != 1) begin fails++; $display("FAIL toggle_fill: got %h lat %0d want %h lat 1", d, lat, e); end
        toggle_mode = 0;
    endtask

    task automatic test_abandon();
        logic ok; logic [31:0] d, e; int lat, k, r0, n0, a0;
        r0 = rd_cmds; n0 = rnext_cnt; a0 = ack_cnt;
        wb_adr_i = 32'h300; wb_we_i = 1'b0; wb_sel_i = 4'hF; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        k = 0;
        while (fml_rd !== 1'b1 && k < 50) begin @(negedge clk); k++; end
        tests++;
        if (fml_rd !== 1'b1) begin fails++; $display("FAIL abandon_rd: fml_rd=%b want 1", fml_rd); end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        repeat (40) @(negedge clk);
        tests++;
        if (ack_cnt != a0) begin fails++; $display("FAIL abandon_noack: got %0d acks want 0", ack_cnt - a0); end
        tests++;
        if (rnext_cnt - n0 != BURST || rd_cmds - r0 != 1) begin
            fails++; $display("FAIL abandon_drain: rnext=%0d reads=%0d want %0d/1", rnext_cnt - n0, rd_cmds - r0, BURST);
        end
        tests++;
        if (rfifo.size() + pend.size() != 0) begin fails++; $display("FAIL abandon_fifo: %0d beats left want 0", rfifo.size() + pend.size()); end
        exp_q.push_back(ref_mem[widx(32'h30C)]);
        wb_access(32'h30C, 1'b0, 32'h0, 4'hF, ok, d, lat);
        e = exp_q.pop_front();
        tests++;
        if (!ok || d !== e || lat != 1) begin fails++; $display("FAIL abandon_next: got %h lat %0d want %h lat 1", d, lat, e); end
    endtask

    task automatic test_reset_mid();
        logic ok; logic [31:0] d, e; int lat, k, cnt, r0;
        wb_adr_i = 32'h400; wb_we_i = 1'b1; wb_dat_i = 32'h1234_5678; wb_sel_i = 4'hF;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        cnt = 0; k = 0;
        while (cnt < 2 && k < 50) begin @(negedge clk); k++; if (fml_wnext === 1'b1) cnt++; end
        tests++;
        if (cnt != 2) begin fails++; $display("FAIL rstmid_wnext: saw %0d beats want 2", cnt); end
        #1 rst = 1'b1;
        #1;
        tests++;
        if ({wb_ack_o, fml_rd, fml_wr, fml_wnext, fml_rnext} !== 5'b0) begin
            fails++; $display("FAIL rstmid_ctl: got %b want 00000", {wb_ack_o, fml_rd, fml_wr, fml_wnext, fml_rnext});
        end
        tests++;
        if (fml_adr !== 26'h0 || wb_dat_o !== 32'h0) begin
            fails++; $display("FAIL rstmid_data: adr=%h dat_o=%h want 0", fml_adr, wb_dat_o);
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        r0 = rd_cmds;
        exp_q.push_back(ref_mem[widx(32'h30C)]);
        wb_access(32'h30C, 1'b0, 32'h0, 4'hF, ok, d, lat);
        repeat (2) @(negedge clk);
        e = exp_q.pop_front();
        tests++;
        if (!ok || d !== e) begin fails++; $display("FAIL rstmid_data_after: ok=%0b got %h want %h", ok, d, e); end
        tests++;
        if (rd_cmds - r0 != 1 || lat <= 1) begin
            fails++; $display("FAIL rstmid_invalid: reads=%0d lat=%0d want 1 miss", rd_cmds - r0, lat);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        test_read_miss();
        test_hit();
        test_write();
        test_rempty_toggle();
        test_abandon();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, limit 200000 ns");
        $fatal(1, "watchdog");
    end
endmodule
